// File: rtl/pipe_front_regs.sv
// Front-end pipeline state: fetch PC, IF/ID and ID/EX stage registers with
// hazard-driven stall/flush/redirect handling and saturating debug event counters.
module pipe_front_regs #(
   parameter int unsigned N      = 10,
   parameter int unsigned CNT_W  = 16,
   parameter logic [31:0] BUBBLE = 32'hB800_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      imem_data_i,
   input  logic             stallF_i,
   input  logic             stallD_i,
   input  logic             flushD_i,
   input  logic             flushE_i,
   input  logic [1:0]       pc_sel_i,
   input  logic [N-1:0]     branch_tgt_i,
   input  logic [N-1:0]     jump_tgt_i,
   input  logic [N-1:0]     ret_addr_i,
   output logic [N-1:0]     pc_o,
   output logic [31:0]      instrD_o,
   output logic [N-1:0]     pcD_o,
   output logic             validD_o,
   output logic [31:0]      instrE_o,
   output logic [N-1:0]     pcE_o,
   output logic             validE_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [1:0]       PC_SEQ    = 2'b00;
   localparam logic [1:0]       PC_BRANCH = 2'b01;
   localparam logic [1:0]       PC_JUMP   = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [N-1:0]     pc_q,        pc_d;
   logic [31:0]      instr_dec_q, instr_dec_d;
   logic [N-1:0]     pc_dec_q,    pc_dec_d;
   logic             valid_dec_q, valid_dec_d;
   logic [31:0]      instr_exe_q, instr_exe_d;
   logic [N-1:0]     pc_exe_q,    pc_exe_d;
   logic             valid_exe_q, valid_exe_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic stall_evt_c;
   logic flush_evt_c;

   // Next fetch PC: a redirect outranks a fetch stall.
   always_comb begin
      pc_d = pc_q + N'(1);
      if (pc_sel_i != PC_SEQ) begin
         case (pc_sel_i)
            PC_BRANCH: pc_d = branch_tgt_i;
            PC_JUMP:   pc_d = jump_tgt_i;
            default:   pc_d = ret_addr_i;
         endcase
      end else if (stallF_i) begin
         pc_d = pc_q;
      end
   end

   // IF/ID: flush beats stall.
   always_comb begin
      instr_dec_d = imem_data_i;
      pc_dec_d    = pc_q;
      valid_dec_d = 1'b1;
      if (flushD_i) begin
         instr_dec_d = BUBBLE;
         pc_dec_d    = '0;
         valid_dec_d = 1'b0;
      end else if (stallD_i) begin
         instr_dec_d = instr_dec_q;
         pc_dec_d    = pc_dec_q;
         valid_dec_d = valid_dec_q;
      end
   end

   // ID/EX: a decode stall inserts a bubble so the held instruction issues once.
   always_comb begin
      instr_exe_d = instr_dec_q;
      pc_exe_d    = pc_dec_q;
      valid_exe_d = valid_dec_q;
      if (flushE_i || stallD_i) begin
         instr_exe_d = BUBBLE;
         pc_exe_d    = '0;
         valid_exe_d = 1'b0;
      end
   end

   // Saturating debug event counters.
   always_comb begin
      stall_evt_c = stallF_i | stallD_i;
      flush_evt_c = flushD_i | flushE_i;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt_c && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt_c && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= '0;
         instr_dec_q <= BUBBLE;
         pc_dec_q    <= '0;
         valid_dec_q <= 1'b0;
         instr_exe_q <= BUBBLE;
         pc_exe_q    <= '0;
         valid_exe_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         instr_dec_q <= instr_dec_d;
         pc_dec_q    <= pc_dec_d;
         valid_dec_q <= valid_dec_d;
         instr_exe_q <= instr_exe_d;
         pc_exe_q    <= pc_exe_d;
         valid_exe_q <= valid_exe_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_o        = pc_q;
   assign instrD_o    = instr_dec_q;
   assign pcD_o       = pc_dec_q;
   assign validD_o    = valid_dec_q;
   assign instrE_o    = instr_exe_q;
   assign pcE_o       = pc_exe_q;
   assign validE_o    = valid_exe_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
